// File: rtl/axis2axi_wr_responder.sv
// Write-path endpoint: turns an incoming AW/W request packet into an AXI4 write
// burst on the local slave and returns the B response as a two-flit packet.
module axis2axi_wr_responder #(
  parameter int ADDR_WIDTH      = 16,
  parameter int ID_W_WIDTH      = 5,
  parameter int AXI_DATA_WIDTH  = 8,
  parameter int AXIS_DATA_WIDTH = 40,
  parameter int ROUTER_X        = 0,
  parameter int ROUTER_Y        = 0,
  parameter int MAX_ROUTERS_X   = 4,
  parameter int MAX_ROUTERS_Y   = 4
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_req_tdata,
  input  logic                       s_axis_req_tvalid,
  input  logic                       s_axis_req_tlast,
  output logic                       s_axis_req_tready,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_resp_tdata,
  output logic                       m_axis_resp_tvalid,
  output logic                       m_axis_resp_tlast,
  input  logic                       m_axis_resp_tready,
  output logic [ID_W_WIDTH-1:0]      m_awid,
  output logic [ADDR_WIDTH-1:0]      m_awaddr,
  output logic [7:0]                 m_awlen,
  output logic [2:0]                 m_awsize,
  output logic [1:0]                 m_awburst,
  output logic                       m_awvalid,
  input  logic                       m_awready,
  output logic [AXI_DATA_WIDTH-1:0]  m_wdata,
  output logic                       m_wlast,
  output logic                       m_wvalid,
  input  logic                       m_wready,
  input  logic [ID_W_WIDTH-1:0]      m_bid,
  input  logic                       m_bvalid,
  output logic                       m_bready,
  output logic                       proto_err_o
);

  localparam int XW = (MAX_ROUTERS_X > 1) ? $clog2(MAX_ROUTERS_X) : 1;
  localparam int YW = (MAX_ROUTERS_Y > 1) ? $clog2(MAX_ROUTERS_Y) : 1;

  localparam int DX_LO = 8;
  localparam int DY_LO = DX_LO + XW;
  localparam int SX_LO = DY_LO + YW;
  localparam int SY_LO = SX_LO + XW;
  localparam int HDR_W = SY_LO + YW;

  localparam int ADDR_LO  = ID_W_WIDTH;
  localparam int LEN_LO   = ADDR_LO + ADDR_WIDTH;
  localparam int SIZE_LO  = LEN_LO + 8;
  localparam int BURST_LO = SIZE_LO + 3;

  localparam logic [7:0] TYPE_AW = 8'h01;
  localparam logic [7:0] TYPE_B  = 8'h02;

  localparam logic [XW-1:0] HOME_X = XW'(ROUTER_X);
  localparam logic [YW-1:0] HOME_Y = YW'(ROUTER_Y);

  localparam logic [2:0] HDR  = 3'd0;
  localparam logic [2:0] SUB  = 3'd1;
  localparam logic [2:0] AW   = 3'd2;
  localparam logic [2:0] W    = 3'd3;
  localparam logic [2:0] BW   = 3'd4;
  localparam logic [2:0] RH   = 3'd5;
  localparam logic [2:0] RS   = 3'd6;
  localparam logic [2:0] DROP = 3'd7;

  logic [2:0]            state_reg;
  logic [XW-1:0]         src_x_reg;
  logic [YW-1:0]         src_y_reg;
  logic [ID_W_WIDTH-1:0] awid_reg;
  logic [ADDR_WIDTH-1:0] awaddr_reg;
  logic [7:0]            awlen_reg;
  logic [2:0]            awsize_reg;
  logic [1:0]            awburst_reg;
  logic [7:0]            cnt_reg;
  logic                  early_reg;
  logic                  drop_pend_reg;
  logic [ID_W_WIDTH-1:0] bid_reg;
  logic                  proto_err_reg;

  logic in_hs;
  logic w_hs;
  logic unused_tdata;

  assign unused_tdata = ^s_axis_req_tdata;

  assign in_hs = s_axis_req_tvalid && s_axis_req_tready;
  assign w_hs  = m_wvalid && m_wready;

  assign m_awid      = awid_reg;
  assign m_awaddr    = awaddr_reg;
  assign m_awlen     = awlen_reg;
  assign m_awsize    = awsize_reg;
  assign m_awburst   = awburst_reg;
  assign m_wlast     = (state_reg == W) && (cnt_reg == awlen_reg);
  assign proto_err_o = proto_err_reg;

  // Gating with ARESETn keeps every handshake output low while reset is held.
  always_comb begin
    s_axis_req_tready  = 1'b0;
    m_awvalid          = 1'b0;
    m_wvalid           = 1'b0;
    m_wdata            = '0;
    m_bready           = 1'b0;
    m_axis_resp_tvalid = 1'b0;
    m_axis_resp_tlast  = 1'b0;
    m_axis_resp_tdata  = '0;
    if (ARESETn) begin
      case (state_reg)
        HDR, SUB, DROP: s_axis_req_tready = 1'b1;
        AW:             m_awvalid = 1'b1;
        W: begin
          if (early_reg) begin
            m_wvalid = 1'b1;
          end else begin
            m_wvalid          = s_axis_req_tvalid;
            m_wdata           = s_axis_req_tdata[AXI_DATA_WIDTH-1:0];
            s_axis_req_tready = m_wready;
          end
        end
        BW: m_bready = 1'b1;
        RH: begin
          m_axis_resp_tvalid = 1'b1;
          m_axis_resp_tdata  = {{(AXIS_DATA_WIDTH-HDR_W){1'b0}},
                                HOME_Y, HOME_X, src_y_reg, src_x_reg, TYPE_B};
        end
        RS: begin
          m_axis_resp_tvalid = 1'b1;
          m_axis_resp_tlast  = 1'b1;
          m_axis_resp_tdata  = {{(AXIS_DATA_WIDTH-ID_W_WIDTH){1'b0}}, bid_reg};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_reg     <= HDR;
      src_x_reg     <= '0;
      src_y_reg     <= '0;
      awid_reg      <= '0;
      awaddr_reg    <= '0;
      awlen_reg     <= '0;
      awsize_reg    <= '0;
      awburst_reg   <= '0;
      cnt_reg       <= '0;
      early_reg     <= 1'b0;
      drop_pend_reg <= 1'b0;
      bid_reg       <= '0;
      proto_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        HDR: if (in_hs) begin
          if (s_axis_req_tdata[7:0] == TYPE_AW) begin
            src_x_reg <= s_axis_req_tdata[SX_LO +: XW];
            src_y_reg <= s_axis_req_tdata[SY_LO +: YW];
            state_reg <= SUB;
          end else begin
            proto_err_reg <= 1'b1;
            if (!s_axis_req_tlast) state_reg <= DROP;
          end
        end
        SUB: if (in_hs) begin
          awid_reg    <= s_axis_req_tdata[0 +: ID_W_WIDTH];
          awaddr_reg  <= s_axis_req_tdata[ADDR_LO +: ADDR_WIDTH];
          awlen_reg   <= s_axis_req_tdata[LEN_LO +: 8];
          awsize_reg  <= s_axis_req_tdata[SIZE_LO +: 3];
          awburst_reg <= s_axis_req_tdata[BURST_LO +: 2];
          if (s_axis_req_tlast) begin
            proto_err_reg <= 1'b1;
            state_reg     <= HDR;
          end else begin
            state_reg <= AW;
          end
        end
        AW: if (m_awready) begin
          cnt_reg       <= '0;
          early_reg     <= 1'b0;
          drop_pend_reg <= 1'b0;
          state_reg     <= W;
        end
        W: if (w_hs) begin
          cnt_reg <= cnt_reg + 8'd1;
          // Once the packet ends early the burst is finished with zero beats.
          if (!early_reg && s_axis_req_tlast && !m_wlast) begin
            early_reg     <= 1'b1;
            proto_err_reg <= 1'b1;
          end
          if (m_wlast) begin
            state_reg <= BW;
            if (!early_reg && !s_axis_req_tlast) begin
              proto_err_reg <= 1'b1;
              drop_pend_reg <= 1'b1;
            end
          end
        end
        BW: if (m_bvalid) begin
          bid_reg   <= m_bid;
          state_reg <= RH;
        end
        RH: if (m_axis_resp_tready) state_reg <= RS;
        RS: if (m_axis_resp_tready) state_reg <= drop_pend_reg ? DROP : HDR;
        DROP: if (in_hs && s_axis_req_tlast) state_reg <= HDR;
        default: state_reg <= HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_axis2axi_wr_responder.sv
// Directed bench for axis2axi_wr_responder: a small AXI slave/monitor records
// every handshake and the main sequence compares them with hand-computed values.
module tb_axis2axi_wr_responder;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [39:0] s_axis_req_tdata = '0;
  logic        s_axis_req_tvalid = 1'b0;
  logic        s_axis_req_tlast = 1'b0;
  logic        s_axis_req_tready;
  logic [39:0] m_axis_resp_tdata;
  logic        m_axis_resp_tvalid;
  logic        m_axis_resp_tlast;
  logic        m_axis_resp_tready = 1'b0;
  logic [4:0]  m_awid;
  logic [15:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst;
  logic        m_awvalid;
  logic        m_awready = 1'b0;
  logic [7:0]  m_wdata;
  logic        m_wlast;
  logic        m_wvalid;
  logic        m_wready = 1'b0;
  logic [4:0]  m_bid = '0;
  logic        m_bvalid = 1'b0;
  logic        m_bready;
  logic        proto_err_o;

  axis2axi_wr_responder #(
    .ADDR_WIDTH(16), .ID_W_WIDTH(5), .AXI_DATA_WIDTH(8), .AXIS_DATA_WIDTH(40),
    .ROUTER_X(3), .ROUTER_Y(2), .MAX_ROUTERS_X(4), .MAX_ROUTERS_Y(4)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_axis_req_tdata(s_axis_req_tdata), .s_axis_req_tvalid(s_axis_req_tvalid),
    .s_axis_req_tlast(s_axis_req_tlast), .s_axis_req_tready(s_axis_req_tready),
    .m_axis_resp_tdata(m_axis_resp_tdata), .m_axis_resp_tvalid(m_axis_resp_tvalid),
    .m_axis_resp_tlast(m_axis_resp_tlast), .m_axis_resp_tready(m_axis_resp_tready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .proto_err_o(proto_err_o)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [4:0]  id;
    logic [15:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          cyc;
  } aw_t;
  typedef struct {
    logic [7:0] data;
    logic       last;
  } w_t;
  typedef struct {
    logic [39:0] data;
    logic        last;
    int          cyc;
  } r_t;

  aw_t aw_q[$];
  w_t  w_q[$];
  r_t  resp_q[$];

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  bit   stall_en = 1'b0;
  bit   b_pend = 1'b0;
  bit   b_hs = 1'b0;
  logic [4:0] b_id = '0;

  always @(posedge ACLK) cyc <= cyc + 1;

  // Slave/monitor: drives readies and B at the falling edge, samples 1 time unit before the rising edge.
  always @(negedge ACLK) begin
    if (b_hs) begin
      m_bvalid = 1'b0;
      b_hs = 1'b0;
    end
    if (b_pend && !m_bvalid) begin
      m_bvalid = 1'b1;
      m_bid = b_id;
      b_pend = 1'b0;
    end
    if (stall_en) begin
      m_awready          = ($urandom_range(0, 1) != 0);
      m_wready           = ($urandom_range(0, 1) != 0);
      m_axis_resp_tready = ($urandom_range(0, 1) != 0);
    end else begin
      m_awready          = 1'b1;
      m_wready           = 1'b1;
      m_axis_resp_tready = 1'b1;
    end
    #4;
    if (ARESETn) begin
      if (m_awvalid && m_awready) begin
        aw_q.push_back('{m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, cyc});
        b_id = m_awid;
      end
      if (m_wvalid && m_wready) begin
        w_q.push_back('{m_wdata, m_wlast});
        if (m_wlast) b_pend = 1'b1;
      end
      if (m_bvalid && m_bready) b_hs = 1'b1;
      if (m_axis_resp_tvalid && m_axis_resp_tready)
        resp_q.push_back('{m_axis_resp_tdata, m_axis_resp_tlast, cyc});
      if (s_axis_req_tvalid && s_axis_req_tready) acc_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] mk_sub(input logic [4:0] id, input logic [15:0] addr,
                                         input logic [7:0] len, input logic [2:0] size,
                                         input logic [1:0] burst);
    return {6'd0, burst, size, len, addr, id};
  endfunction

  // Called and returns at a falling edge; leaves tvalid high for back-to-back flits.
  task automatic send_flit(input logic [39:0] d, input logic l);
    int k = 0;
    bit done = 1'b0;
    s_axis_req_tdata  = d;
    s_axis_req_tlast  = l;
    s_axis_req_tvalid = 1'b1;
    while (!done && k < 300) begin
      #4;
      if (s_axis_req_tready) done = 1'b1;
      @(negedge ACLK);
      k++;
    end
    chk("send_accept", done, 1);
  endtask

  task automatic wait_resp(input int n);
    int k = 0;
    while (resp_q.size() < n && k < 500) begin
      @(negedge ACLK);
      k++;
    end
    chk("resp_arrived", resp_q.size() >= n, 1);
  endtask

  task automatic clear_logs();
    aw_q.delete();
    w_q.delete();
    resp_q.delete();
  endtask

  task automatic do_reset();
    ARESETn = 1'b0;
    s_axis_req_tvalid = 1'b0;
    b_pend = 1'b0;
    b_hs = 1'b0;
    m_bvalid = 1'b0;
    @(negedge ACLK);
    ARESETn = 1'b1;
    clear_logs();
    @(negedge ACLK);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;

    // Reset state
    #1;
    chk("rst_tready", s_axis_req_tready, 0);
    chk("rst_awvalid", m_awvalid, 0);
    chk("rst_wvalid", m_wvalid, 0);
    chk("rst_bready", m_bready, 0);
    chk("rst_rvalid", m_axis_resp_tvalid, 0);
    chk("rst_rdata", m_axis_resp_tdata, 0);
    chk("rst_awaddr", m_awaddr, 0);
    chk("rst_proto", proto_err_o, 0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    #1;
    chk("hdr_tready", s_axis_req_tready, 1);
    @(negedge ACLK);

    // Single-beat write from src (2,1)
    send_flit(40'h6B01, 1'b0);
    send_flit(mk_sub(5'd5, 16'h1234, 8'd0, 3'd0, 2'd1), 1'b0);
    send_flit(40'hA5, 1'b1);
    s_axis_req_tvalid = 1'b0;
    wait_resp(2);
    chk("sb_aw_n", aw_q.size(), 1);
    chk("sb_awid", aw_q[0].id, 5);
    chk("sb_awaddr", aw_q[0].addr, 16'h1234);
    chk("sb_awlen", aw_q[0].len, 0);
    chk("sb_awsize", aw_q[0].size, 0);
    chk("sb_awburst", aw_q[0].burst, 1);
    chk("sb_w_n", w_q.size(), 1);
    chk("sb_wdata", w_q[0].data, 8'hA5);
    chk("sb_wlast", w_q[0].last, 1);
    chk("sb_r0_data", resp_q[0].data, 40'hB602);
    chk("sb_r0_last", resp_q[0].last, 0);
    chk("sb_r1_data", resp_q[1].data, 40'h5);
    chk("sb_r1_last", resp_q[1].last, 1);
    chk("sb_proto", proto_err_o, 0);
    clear_logs();

    // 4-beat burst with random stalls, src (1,3)
    stall_en = 1'b1;
    send_flit(40'hDB01, 1'b0);
    send_flit(mk_sub(5'd3, 16'h0100, 8'd3, 3'd0, 2'd1), 1'b0);
    send_flit(40'h11, 1'b0);
    send_flit(40'h22, 1'b0);
    send_flit(40'h33, 1'b0);
    send_flit(40'h44, 1'b1);
    s_axis_req_tvalid = 1'b0;
    wait_resp(2);
    stall_en = 1'b0;
    chk("b4_awid", aw_q[0].id, 3);
    chk("b4_awaddr", aw_q[0].addr, 16'h0100);
    chk("b4_awlen", aw_q[0].len, 3);
    chk("b4_w_n", w_q.size(), 4);
    chk("b4_w0", {w_q[0].data, w_q[0].last}, {8'h11, 1'b0});
    chk("b4_w1", {w_q[1].data, w_q[1].last}, {8'h22, 1'b0});
    chk("b4_w2", {w_q[2].data, w_q[2].last}, {8'h33, 1'b0});
    chk("b4_w3", {w_q[3].data, w_q[3].last}, {8'h44, 1'b1});
    chk("b4_r0_data", resp_q[0].data, 40'hBD02);
    chk("b4_r1", {resp_q[1].data, resp_q[1].last}, {40'h3, 1'b1});
    chk("b4_proto", proto_err_o, 0);
    clear_logs();

    // Back-to-back packets, no idle cycle between them
    send_flit(40'h6B01, 1'b0);
    send_flit(mk_sub(5'd1, 16'h0010, 8'd0, 3'd0, 2'd1), 1'b0);
    send_flit(40'h5A, 1'b1);
    send_flit(40'h6B01, 1'b0);
    send_flit(mk_sub(5'd2, 16'h0020, 8'd0, 3'd0, 2'd1), 1'b0);
    send_flit(40'hC3, 1'b1);
    s_axis_req_tvalid = 1'b0;
    wait_resp(4);
    chk("bb_aw_n", aw_q.size(), 2);
    chk("bb_aw2_addr", aw_q[1].addr, 16'h0020);
    chk("bb_order", aw_q[1].cyc > resp_q[1].cyc, 1);
    chk("bb_w1", {w_q[1].data, w_q[1].last}, {8'hC3, 1'b1});
    chk("bb_r1", {resp_q[1].data, resp_q[1].last}, {40'h1, 1'b1});
    chk("bb_r3", {resp_q[3].data, resp_q[3].last}, {40'h2, 1'b1});
    chk("bb_proto", proto_err_o, 0);
    clear_logs();

    // Unknown type 0x03, three flits, all dropped
    a0 = acc_cnt;
    send_flit(40'h6B03, 1'b0);
    send_flit(40'h1111, 1'b0);
    send_flit(40'h2222, 1'b1);
    s_axis_req_tvalid = 1'b0;
    repeat (5) @(negedge ACLK);
    chk("bad_acc", acc_cnt - a0, 3);
    chk("bad_aw_n", aw_q.size(), 0);
    chk("bad_w_n", w_q.size(), 0);
    chk("bad_r_n", resp_q.size(), 0);
    chk("bad_proto", proto_err_o, 1);
    chk("bad_tready", s_axis_req_tready, 1);

    do_reset();
    chk("rst2_proto", proto_err_o, 0);

    // Early tlast: len=3, packet ends on the 2nd data flit
    send_flit(40'h6B01, 1'b0);
    send_flit(mk_sub(5'd7, 16'h0200, 8'd3, 3'd0, 2'd1), 1'b0);
    send_flit(40'h77, 1'b0);
    send_flit(40'h88, 1'b1);
    s_axis_req_tvalid = 1'b0;
    wait_resp(2);
    chk("et_w_n", w_q.size(), 4);
    chk("et_w0", {w_q[0].data, w_q[0].last}, {8'h77, 1'b0});
    chk("et_w1", {w_q[1].data, w_q[1].last}, {8'h88, 1'b0});
    chk("et_w2", {w_q[2].data, w_q[2].last}, {8'h00, 1'b0});
    chk("et_w3", {w_q[3].data, w_q[3].last}, {8'h00, 1'b1});
    chk("et_r1", {resp_q[1].data, resp_q[1].last}, {40'h7, 1'b1});
    chk("et_proto", proto_err_o, 1);

    do_reset();

    // Reset asserted while W beat 2 is on the bus
    send_flit(40'h6B01, 1'b0);
    send_flit(mk_sub(5'd9, 16'h0300, 8'd3, 3'd0, 2'd1), 1'b0);
    send_flit(40'h01, 1'b0);
    s_axis_req_tdata = 40'h02;
    ARESETn = 1'b0;
    #1;
    chk("mr_tready", s_axis_req_tready, 0);
    chk("mr_wvalid", m_wvalid, 0);
    chk("mr_wdata", m_wdata, 0);
    chk("mr_wlast", m_wlast, 0);
    chk("mr_awvalid", m_awvalid, 0);
    chk("mr_awaddr", m_awaddr, 0);
    chk("mr_awlen", m_awlen, 0);
    chk("mr_bready", m_bready, 0);
    chk("mr_rvalid", m_axis_resp_tvalid, 0);
    chk("mr_rdata", m_axis_resp_tdata, 0);
    chk("mr_proto", proto_err_o, 0);
    s_axis_req_tvalid = 1'b0;
    @(negedge ACLK);
    ARESETn = 1'b1;
    clear_logs();
    @(negedge ACLK);

    // Fresh packet after reset
    send_flit(40'hDB01, 1'b0);
    send_flit(mk_sub(5'h1F, 16'hFFFF, 8'd0, 3'd0, 2'd1), 1'b0);
    send_flit(40'h3C, 1'b1);
    s_axis_req_tvalid = 1'b0;
    wait_resp(2);
    chk("fr_aw", {aw_q[0].id, aw_q[0].addr, aw_q[0].len}, {5'h1F, 16'hFFFF, 8'd0});
    chk("fr_w_n", w_q.size(), 1);
    chk("fr_w0", {w_q[0].data, w_q[0].last}, {8'h3C, 1'b1});
    chk("fr_r0", {resp_q[0].data, resp_q[0].last}, {40'hBD02, 1'b0});
    chk("fr_r1", {resp_q[1].data, resp_q[1].last}, {40'h1F, 1'b1});
    chk("fr_proto", proto_err_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
